// File: rtl/pio_loader.sv
// pio_loader: configuration sequencer and TX-data feeder for the pio block.
//
// After a start pulse the block loads program words from an external
// synchronous ROM, writes PEND/DIV/GRPS/SHIFT to every machine selected by
// sm_mask, issues EN, and then enters RUN. In RUN it forwards a valid/ready
// stream into the selected machines' TX FIFOs as PUSH actions.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start, stop       one-cycle control pulses
//   prog_len, sm_mask program length and machine mask (captured on start)
//   pend_val, div_val, grps_val, shift_val
//                     per-machine configuration values (captured on start)
//   prog_addr, prog_data
//                     ROM address out, ROM data in (one-cycle read latency)
//   s_valid, s_sm, s_data, s_ready
//                     TX stream handshake
//   tx_full           pio TX FIFO full flags
//   action, index, mindex, din
//                     pio command port (one-cycle actions)
//   busy, running     sequencer status
//
// Optional feature macro: PIO_LOADER_PREDISABLE_EN
//   When defined, one extra cycle issuing EN din=0 precedes the program
//   load so reprogramming never runs against active machines.
//
// Timing note: every action is registered from the state active in the
// cycle before it becomes visible. In LOAD this lines the ROM's one-cycle
// read latency up with the INSTR word, so the visible action trace trails
// the internal state by one cycle throughout.

module pio_loader #(
  parameter int PROG_DEPTH = 32,
  parameter int NUM_SM     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [5:0]  prog_len,
  input  logic [3:0]  sm_mask,
  input  logic [31:0] pend_val,
  input  logic [23:0] div_val,
  input  logic [31:0] grps_val,
  input  logic [31:0] shift_val,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic        s_valid,
  input  logic [1:0]  s_sm,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic [3:0]  tx_full,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  output logic        busy,
  output logic        running
);

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;
  localparam logic [3:0] ACT_SHIFT = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_FILL   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_CFG    = 3'd4,
    ST_ENABLE = 3'd5,
    ST_RUN    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  len_q, len_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] pend_q, pend_d;
  logic [23:0] div_q, div_d;
  logic [31:0] grps_q, grps_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  sm_q, sm_d;
  logic [1:0]  step_q, step_d;
  logic [4:0]  prog_addr_q, prog_addr_d;
  logic [3:0]  action_q, action_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  mindex_q, mindex_d;
  logic [31:0] din_q, din_d;
  logic        busy_q, busy_d;
  logic        running_q, running_d;
  logic        ready_s;
  logic [2:0]  first_s;
  logic [2:0]  next_s;

  // Lowest selected machine at index >= from: {found, index}.
  function automatic logic [2:0] find_sm(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    // Scan downward so the lowest qualifying index is the one left in res.
    for (int i = NUM_SM - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) begin
        res = {1'b1, 2'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mask_d      = mask_q;
    pend_d      = pend_q;
    div_d       = div_q;
    grps_d      = grps_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    sm_d        = sm_q;
    step_d      = step_q;
    prog_addr_d = prog_addr_q;
    action_d    = ACT_NONE;
    index_d     = 5'd0;
    mindex_d    = 2'd0;
    din_d       = 32'd0;
    ready_s     = 1'b0;
    first_s     = find_sm(mask_q, 3'd0);
    next_s      = find_sm(mask_q, {1'b0, sm_q} + 3'd1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = (int'(prog_len) > PROG_DEPTH) ? 6'(PROG_DEPTH) : prog_len;
          mask_d      = sm_mask;
          pend_d      = pend_val;
          div_d       = div_val;
          grps_d      = grps_val;
          shift_d     = shift_val;
          prog_addr_d = 5'd0;
          cnt_d       = 5'd0;
          step_d      = 2'd0;
`ifdef PIO_LOADER_PREDISABLE_EN
          state_d     = ST_PRE;
`else
          state_d     = ST_FILL;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRE: begin
        action_d = ACT_EN;
        din_d    = 32'd0;
        state_d  = ST_FILL;
      end

      // prog_addr=0 is on the bus this cycle; word 0 arrives next cycle.
      ST_FILL: begin
        prog_addr_d = prog_addr_q + 5'd1;
        cnt_d       = 5'd0;
        if (len_q != 6'd0) begin
          state_d = ST_LOAD;
        end else if (first_s[2]) begin
          state_d = ST_CFG;
          sm_d    = first_s[1:0];
          step_d  = 2'd0;
        end else begin
          state_d = ST_ENABLE;
        end
      end

      // ROM presents word cnt_q while prog_addr already points at cnt_q+1.
      ST_LOAD: begin
        action_d    = ACT_INSTR;
        index_d     = cnt_q;
        din_d       = {16'd0, prog_data};
        prog_addr_d = prog_addr_q + 5'd1;
        cnt_d       = cnt_q + 5'd1;
        if ({1'b0, cnt_q} != (len_q - 6'd1)) begin
          state_d = ST_LOAD;
        end else if (first_s[2]) begin
          state_d = ST_CFG;
          sm_d    = first_s[1:0];
          step_d  = 2'd0;
        end else begin
          state_d = ST_ENABLE;
        end
      end

      ST_CFG: begin
        mindex_d = sm_q;
        case (step_q)
          2'd0: begin action_d = ACT_PEND;  din_d = pend_q;          end
          2'd1: begin action_d = ACT_DIV;   din_d = {8'd0, div_q};   end
          2'd2: begin action_d = ACT_GRPS;  din_d = grps_q;          end
          2'd3: begin action_d = ACT_SHIFT; din_d = shift_q;         end
          default: begin action_d = ACT_NONE; din_d = 32'd0;       end
        endcase
        step_d = step_q + 2'd1;
        if (step_q != 2'd3) begin
          state_d = ST_CFG;
        end else if (next_s[2]) begin
          sm_d = next_s[1:0];
        end else begin
          state_d = ST_ENABLE;
        end
      end

      ST_ENABLE: begin
        action_d = ACT_EN;
        din_d    = {28'd0, mask_q};
        state_d  = ST_RUN;
      end

      // stop takes priority over a word offered in the same cycle.
      ST_RUN: begin
        if (stop) begin
          action_d = ACT_EN;
          din_d    = 32'd0;
          state_d  = ST_IDLE;
        end else begin
          ready_s = running_q & ~tx_full[s_sm] & mask_q[s_sm];
          if (s_valid && ready_s) begin
            action_d = ACT_PUSH;
            mindex_d = s_sm;
            din_d    = s_data;
          end else begin
            action_d = ACT_NONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy covers the whole bring-up and drops as running rises.
    busy_d    = (state_d != ST_IDLE) && (state_q != ST_RUN);
    running_d = (state_q == ST_RUN) && !stop;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= 6'd0;
      mask_q      <= 4'd0;
      pend_q      <= 32'd0;
      div_q       <= 24'd0;
      grps_q      <= 32'd0;
      shift_q     <= 32'd0;
      cnt_q       <= 5'd0;
      sm_q        <= 2'd0;
      step_q      <= 2'd0;
      prog_addr_q <= 5'd0;
      action_q    <= ACT_NONE;
      index_q     <= 5'd0;
      mindex_q    <= 2'd0;
      din_q       <= 32'd0;
      busy_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      div_q       <= div_d;
      grps_q      <= grps_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      sm_q        <= sm_d;
      step_q      <= step_d;
      prog_addr_q <= prog_addr_d;
      action_q    <= action_d;
      index_q     <= index_d;
      mindex_q    <= mindex_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      running_q   <= running_d;
    end
  end

  assign prog_addr = prog_addr_q;
  assign action    = action_q;
  assign index     = index_q;
  assign mindex    = mindex_q;
  assign din       = din_q;
  assign busy      = busy_q;
  assign running   = running_q;
  assign s_ready   = ready_s;

endmodule

// File: tb/tb_pio_loader.sv
// Self-checking bench for pio_loader: table-driven bring-up scenarios plus
// hand-written stream, stop, blocked-machine and reset sequences.

module tb_pio_loader;

  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_INSTR = 4'd1;
  localparam logic [3:0] A_PEND  = 4'd2;
  localparam logic [3:0] A_PUSH  = 4'd4;
  localparam logic [3:0] A_GRPS  = 4'd5;
  localparam logic [3:0] A_EN    = 4'd6;
  localparam logic [3:0] A_DIV   = 4'd7;
  localparam logic [3:0] A_SHIFT = 4'd10;

  localparam logic [31:0] PEND_V  = 32'h4000_3000;
  localparam logic [23:0] DIV_V   = 24'h00_0200;
  localparam logic [31:0] GRPS_V  = 32'h4010_0000;
  localparam logic [31:0] SHIFT_V = 32'h0008_0000;

`ifdef PIO_LOADER_PREDISABLE_EN
  localparam int PRE_OFS = 1;
`else
  localparam int PRE_OFS = 0;
`endif

  logic        clk, reset, start, stop;
  logic [5:0]  prog_len;
  logic [3:0]  sm_mask;
  logic [31:0] pend_val, grps_val, shift_val;
  logic [23:0] div_val;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic        s_valid, s_ready;
  logic [1:0]  s_sm;
  logic [31:0] s_data;
  logic [3:0]  tx_full;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy, running;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] len;
    logic [3:0] mask;
    int         lat;
    int         restart_at;
  } scen_t;

  typedef struct packed {
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [1:0]  mi;
    logic [31:0] d;
  } act_t;

  scen_t scen [4];
  act_t  exp_q [$];
  act_t  got_q [$];

  pio_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .prog_len  (prog_len),
    .sm_mask   (sm_mask),
    .pend_val  (pend_val),
    .div_val   (div_val),
    .grps_val  (grps_val),
    .shift_val (shift_val),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .s_valid   (s_valid),
    .s_sm      (s_sm),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .tx_full   (tx_full),
    .action    (action),
    .index     (index),
    .mindex    (mindex),
    .din       (din),
    .busy      (busy),
    .running   (running)
  );

  function automatic logic [15:0] rom_word(input logic [4:0] a);
    return {8'hA5, 3'b011, a};
  endfunction

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model with one-cycle read latency.
  always @(posedge clk) prog_data <= rom_word(prog_addr);

  // Hard time limit.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] fmt(input act_t a);
    return {20'd0, a.act, 3'd0, (a.act == A_INSTR) ? a.idx : {3'd0, a.mi}, a.d};
  endfunction

  task automatic bringup(input int si);
    int L;
    int cyc;
    int lat;
    exp_q.delete();
    got_q.delete();
`ifdef PIO_LOADER_PREDISABLE_EN
    exp_q.push_back('{A_EN, 5'd0, 2'd0, 32'd0});
`endif
    L = (scen[si].len > 6'd32) ? 32 : int'(scen[si].len);
    for (int k = 0; k < L; k++)
      exp_q.push_back('{A_INSTR, 5'(k), 2'd0, {16'd0, rom_word(5'(k))}});
    for (int m = 0; m < 4; m++) begin
      if (scen[si].mask[m]) begin
        exp_q.push_back('{A_PEND,  5'd0, 2'(m), PEND_V});
        exp_q.push_back('{A_DIV,   5'd0, 2'(m), {8'd0, DIV_V}});
        exp_q.push_back('{A_GRPS,  5'd0, 2'(m), GRPS_V});
        exp_q.push_back('{A_SHIFT, 5'd0, 2'(m), SHIFT_V});
      end
    end
    exp_q.push_back('{A_EN, 5'd0, 2'd0, {28'd0, scen[si].mask}});

    @(negedge clk);
    prog_len = scen[si].len; sm_mask = scen[si].mask;
    pend_val = PEND_V; div_val = DIV_V; grps_val = GRPS_V; shift_val = SHIFT_V;
    start = 1'b1;
    @(negedge clk);
    // Inputs changed after the start edge must have no effect.
    start = 1'b0;
    prog_len = 6'd1; sm_mask = 4'hF;
    pend_val = 32'hDEAD_BEEF; div_val = 24'hFFFFFF; grps_val = 32'h1234_5678; shift_val = 32'h8765_4321;
    cyc = 0;
    lat = -1;
    chk("busy_after_start", busy == 1'b1, {63'd0, busy}, 64'd1);
    while (cyc <= 200) begin
      if (action != A_NONE) got_q.push_back('{action, index, mindex, din});
      if (running) begin
        lat = cyc;
        break;
      end
      start = (cyc == scen[si].restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", lat == scen[si].lat, 64'(lat), 64'(scen[si].lat));
    chk("busy_low_in_run", busy == 1'b0, {63'd0, busy}, 64'd0);
    chk("action_count", got_q.size() == exp_q.size(), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("trace[%0d]", i), fmt(got_q[i]) == fmt(exp_q[i]), fmt(got_q[i]), fmt(exp_q[i]));
    end
  endtask

  task automatic stream(input int n, input logic [31:0] base, input int st0, input int stlen);
    int sent, got, cyc, first, last;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    while (got < n && cyc < 100) begin
      @(negedge clk);
      if (action == A_PUSH) begin
        chk("push_data", (din == base + 32'(got)) && (mindex == 2'd0),
            {30'd0, mindex, din}, {32'd0, base + 32'(got)});
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      tx_full = ((cyc >= st0) && (cyc < st0 + stlen)) ? 4'b0001 : 4'b0000;
      s_valid = (sent < n);
      s_sm    = 2'd0;
      s_data  = base + 32'(sent);
      #1;
      if (tx_full[0]) chk("stall_ready", s_ready == 1'b0, {63'd0, s_ready}, 64'd0);
      if (s_valid && s_ready) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    tx_full = 4'b0000;
    chk("push_count", got == n, 64'(got), 64'(n));
    chk("push_span", (last - first) == (n - 1 + stlen), 64'(last - first), 64'(n - 1 + stlen));
  endtask

  task automatic do_stop(input logic [1:0] sm);
    @(negedge clk);
    stop = 1'b1; s_valid = 1'b1; s_sm = sm; s_data = 32'hCAFE_0001; tx_full = 4'b0000;
    #1;
    chk("stop_ready", s_ready == 1'b0, {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    stop = 1'b0; s_valid = 1'b0;
    chk("stop_en", (action == A_EN) && (din == 32'd0) && (running == 1'b0),
        {27'd0, running, action, din}, {28'd0, A_EN, 32'd0});
    @(negedge clk);
    chk("stop_idle", (action == A_NONE) && (busy == 1'b0) && (running == 1'b0),
        {58'd0, busy, running, action}, 64'd0);
  endtask

  initial begin
    scen[0] = '{6'd4,  4'b0001, 11 + PRE_OFS, -1};
    scen[1] = '{6'd0,  4'b1010, 11 + PRE_OFS, -1};
    scen[2] = '{6'd40, 4'b0001, 39 + PRE_OFS, 6};
    scen[3] = '{6'd0,  4'b0000, 3 + PRE_OFS,  -1};

    reset = 1'b0; start = 1'b0; stop = 1'b0;
    prog_len = 6'd0; sm_mask = 4'd0;
    pend_val = 32'd0; div_val = 24'd0; grps_val = 32'd0; shift_val = 32'd0;
    s_valid = 1'b0; s_sm = 2'd0; s_data = 32'd0; tx_full = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {action, index, mindex, din, busy, running, s_ready, prog_addr} == 52'd0,
        {12'd0, action, index, mindex, din, busy, running, s_ready, prog_addr}, 64'd0);
    reset = 1'b1;
    // IDLE ignores stop.
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("idle_stop_ignored", (action == A_NONE) && (busy == 1'b0), {59'd0, busy, action}, 64'd0);

    for (int si = 0; si < 4; si++) begin
      bringup(si);
      if (si == 0) begin
        stream(10, 32'h30, -1, 0);
        stream(10, 32'h40, 3, 5);
      end
      if (si == 1) begin
        s_valid = 1'b1; s_sm = 2'd0; s_data = 32'h77;
        repeat (5) begin
          @(negedge clk);
          #1;
          chk("blocked_ready", s_ready == 1'b0, {63'd0, s_ready}, 64'd0);
          chk("blocked_nopush", action != A_PUSH, {60'd0, action}, {60'd0, A_NONE});
        end
        s_valid = 1'b0; s_sm = 2'd3;
        #1;
        chk("selected_ready", s_ready == 1'b1, {63'd0, s_ready}, 64'd1);
      end
      do_stop((si == 1) ? 2'd1 : 2'd0);
    end

    // Asynchronous reset in the middle of CFG.
    @(negedge clk);
    prog_len = 6'd0; sm_mask = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_cfg_active", (busy == 1'b1) && (action == A_PEND || action == A_DIV ||
        action == A_GRPS || action == A_SHIFT), {59'd0, busy, action}, {59'd1, A_PEND});
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs",
        {action, index, mindex, din, busy, running, s_ready, prog_addr} == 52'd0,
        {12'd0, action, index, mindex, din, busy, running, s_ready, prog_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bringup(0);
    do_stop(2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_loader.md
Name: pio_loader

Overview:
- Configuration sequencer and TX-data feeder for the pio block.
- After a start pulse it performs the full bring-up through the pio action/index/mindex/din port:
  - loads program words from an external synchronous ROM;
  - writes PEND, DIV, GRPS and SHIFT for each selected state machine;
  - issues EN.
- It then enters RUN, where it forwards a valid/ready data stream into the selected machines' TX FIFOs as PUSH actions, respecting tx_full.

Parameters:
- PROG_DEPTH, 32, maximum program words; also the clamp for prog_len.
- NUM_SM, 4, number of state machines addressed by mindex.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins the load sequence from IDLE
- stop  in  1  one-cycle pulse; in RUN, disables machines and returns to IDLE
- prog_len  in  6  number of program words to load
- sm_mask  in  4  machines to configure/enable (bit m = machine m)
- pend_val  in  32  PEND (exec ctrl) value, same for all selected machines
- div_val  in  24  clock divider value
- grps_val  in  32  pin groups value
- shift_val  in  32  shift control value
- prog_addr  out  5  ROM address; data returns one cycle later
- prog_data  in  16  ROM read data
- s_valid  in  1  TX data valid
- s_sm  in  2  target machine for s_data
- s_data  in  32  TX word
- s_ready  out  1  TX word accepted this cycle when s_valid & s_ready
- tx_full  in  4  pio TX FIFO full flags
- action  out  4  pio action (NONE=0 INSTR=1 PEND=2 PUSH=4 GRPS=5 EN=6 DIV=7 SHIFT=10)
- index  out  5  instruction index for INSTR
- mindex  out  2  machine index
- din  out  32  action data
- busy  out  1  high from the cycle after start until RUN is entered
- running  out  1  high while in RUN

Behaviour:
- Reset values: every output is 0 (action=NONE, busy=0, running=0, s_ready=0, prog_addr=0), state=IDLE.
- All outputs are registered.
- Every non-NONE action lasts exactly one cycle; action returns to NONE otherwise.
- Inputs prog_len, sm_mask and all *_val inputs are captured on the start cycle; later changes have no effect until the next start.
- States: IDLE -> FILL -> LOAD -> CFG -> ENABLE -> RUN -> IDLE.
- IDLE:
  - start -> FILL.
  - stop is ignored.
- FILL (1 cycle):
  - prog_addr=0, action NONE.
  - Effective length L = min(prog_len, PROG_DEPTH).
  - L=0 -> CFG directly.
- LOAD (L cycles):
  - Cycle k issues INSTR, index=k, din={16'b0, prog_data}, with prog_addr=k+1 driven concurrently.
  - After index L-1 -> CFG.
- CFG:
  - Visits each set bit m of sm_mask in ascending order.
  - For each m, issues four consecutive cycles: PEND(pend_val), DIV({8'b0, div_val}), GRPS(grps_val), SHIFT(shift_val), all with mindex=m.
  - sm_mask=0 -> CFG takes zero cycles.
- ENABLE (1 cycle):
  - action=EN, din={28'b0, sm_mask}, mindex=0.
  - Then -> RUN.
- Start-to-running latency = L + 4*N + 3 cycles, where N = popcount(sm_mask).
- RUN:
  - running=1.
  - s_ready = ~tx_full[s_sm] & sm_mask[s_sm] (registered-input evaluation; combinational from s_sm/tx_full is allowed).
  - On s_valid & s_ready the next cycle carries action=PUSH, mindex=s_sm, din=s_data.
  - Sustains one PUSH per cycle.
  - s_sm not in sm_mask -> s_ready=0 indefinitely.
- stop in RUN:
  - s_ready forced 0 that cycle; any PUSH already registered still issues.
  - Next action is EN din=0, then -> IDLE.
  - stop and an accepted word in the same cycle: stop wins, word not accepted.
- start while busy or running is ignored.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs cleared. The pio is not reset by this block; a new start redoes the full sequence.

Optional Feature:
- Macro PIO_LOADER_PREDISABLE_EN.
- Defined:
  - FILL is preceded by one extra cycle issuing EN din=0, so reprogramming never runs against active machines.
  - Start-to-running latency becomes L + 4*N + 4.
- Undefined: no pre-disable, latency L + 4*N + 3.

Test Plan:
- Bring-up: prog_len=4, sm_mask=4'b0001, pend=0x40003000, div=0x0200, grps=0x40100000, shift=0x00080000.
  - Required action trace: INSTR idx0..3 with ROM words, then PEND, DIV, GRPS, SHIFT on mindex 0, then EN din=1.
  - running=1 exactly 11 cycles after the start edge.
- Stream: in RUN, push 0x30..0x39 to s_sm=0 with tx_full=0 -> ten consecutive PUSH actions with matching din.
  - Raise tx_full[0] for 5 cycles mid-stream -> s_ready=0, no PUSH, no data loss.
- Multi-machine: sm_mask=4'b1010, prog_len=0 -> CFG on mindex 1 then 3 (8 actions), EN din=0xA, latency 11.
  - Then s_sm=0 -> s_ready stays 0.
- Clamp/edge: prog_len=40 -> exactly 32 INSTR actions, idx 0..31.
- Stop/restart: stop during RUN with s_valid=1 -> no PUSH accepted, EN din=0, IDLE.
  - start during LOAD is ignored.
  - reset low mid-CFG -> all outputs 0 asynchronously.
  - A subsequent start redoes the full sequence.
- Macro: with PIO_LOADER_PREDISABLE_EN, the first action after start is EN din=0 and the scenario-1 latency is 12.
